// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with
// WAIT_CYCLES wait states. Define MEM_RESPONDER_ERR_EN to enable address error checking.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic          write;
    logic          bad;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } req_t;

  logic [1:0]  state;
  logic [3:0]  cnt;
  req_t        req_q;
  logic        addr_bad;
  logic        commit;
  logic [31:0] mem [DEPTH];

`ifdef MEM_RESPONDER_ERR_EN
  assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
  // Byte offset and high address bits are dropped so addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign addr_bad = 1'b0;
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign commit    = (state == S_WAIT) && (cnt == 4'd0);

  // Storage is never reset; a reset during WAIT leaves state IDLE so commit stays low.
  always_ff @(posedge clk) begin
    if (commit && req_q.write && !req_q.bad) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.wstrb[b]) mem[req_q.idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state       <= S_WAIT;
            cnt         <= 4'(WAIT_CYCLES);
            req_q.write <= req_write;
            req_q.bad   <= addr_bad;
            req_q.idx   <= req_addr[AW+1:2];
            req_q.wdata <= req_wdata;
            req_q.wstrb <= req_wstrb;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= req_q.bad;
            resp_rdata <= (req_q.write || req_q.bad) ? 32'd0 : mem[req_q.idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder; hand sequences cover backpressure,
// reset mid-operation and the MEM_RESPONDER_ERR_EN / wrap addressing paths.
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with resp_ready held high: latency, data, error, return to IDLE.
  task automatic do_req(input string nm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input bit exp_err);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 20) begin tick(); cyc++; end
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin tick(); cyc++; end
    chk({nm, " latency"}, 32'(cyc), 32'(W + 1));
    chk({nm, " rdata"}, resp_rdata, exp_rdata);
    chk({nm, " err"}, 32'(resp_err), 32'(exp_err));
    tick();
    chk({nm, " idle"}, {30'd0, busy, resp_valid}, 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0};
    vt[3] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vt[4] = '{1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vt[5] = '{1'b1, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[6] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vt[7] = '{1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vt[8] = '{1'b1, 32'h3FC, 32'h12345678, 4'hC, 32'h0,        1'b0};
    vt[9] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h12340000, 1'b0};
  end

  initial begin
    #2;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Word 0x3FC is written before it is ever read, so its unwritten bytes are
    // uninitialised: write the full word first.
    do_req("init3fc", 1'b1, 32'h3FC, 32'h0, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      do_req($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb,
             vt[i].exp_rdata, vt[i].exp_err);

    // Backpressure: response must hold for 5 cycles while a competing request is ignored.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
    tick();
    req_write = 1'b1; req_wdata = 32'h0; req_wstrb = 4'hF;
    for (int c = 0; c < 20 && !resp_valid; c++) tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp resp_valid", 32'(resp_valid), 32'd1);
      chk("bp resp_rdata", resp_rdata, 32'hDE22BE44);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      chk("bp busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("bp release idle", {30'd0, busy, resp_valid}, 32'd0);
    chk("bp release ready", 32'(req_ready), 32'd1);

    // Reset during WAIT of a write: outputs clear at once, write is dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_wstrb = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid rdata held", resp_rdata, 32'hDE22BE44);
    reset = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst req_ready", 32'(req_ready), 32'd1);
    chk("mid rst rdata", resp_rdata, 32'd0);
    chk("mid rst valid", 32'(resp_valid), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    do_req("after rst rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    do_req("rd10 unchanged", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

`ifdef MEM_RESPONDER_ERR_EN
    do_req("err misalign", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req("err range wr", 1'b1, 32'(4 * DEPTH), 32'h55555555, 4'hF, 32'h0, 1'b1);
    do_req("err word0", 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
`else
    do_req("wrap misalign", 1'b0, 32'h12, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    do_req("wrap wr", 1'b1, 32'(4 * DEPTH + 4), 32'h77777777, 4'hF, 32'h0, 1'b0);
    do_req("wrap rd", 1'b0, 32'h4, 32'h0, 4'h0, 32'h77777777, 1'b0);
    do_req("wrap word0", 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
